adv7513_cfg_seq: RTL and testbench

ADV7513_CFG_SEQ -- requirements
Module: adv7513_cfg_seq

---
 rtl/adv7513_pkg.sv | 26 ++
 rtl/adv7513_cfg_rom.sv | 41 ++++
 rtl/adv7513_cfg_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_adv7513_cfg_seq.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adv7513_pkg.sv
// rtl/adv7513_pkg.sv - shared constants and state encoding for the ADV7513 config sequencer
package adv7513_pkg;

  // Default 7-bit ADV7513 I2C address (0x72 in 8-bit write form)
  localparam logic [6:0] DEF_CHIP_ADDR = 7'h39;

  // Hot-plug status register and the bit within it that reflects HPD
  localparam logic [7:0] REG_HPD = 8'h42;
  localparam int         HPD_BIT = 6;

  // Number of entries actually populated in the init ROM
  localparam int         INIT_LEN = 16;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WR_ISSUE   = 4'd1,
    ST_WR_WAIT    = 4'd2,
    ST_READY      = 4'd3,
    ST_POLL_ISSUE = 4'd4,
    ST_POLL_WAIT  = 4'd5,
    ST_DBG_ISSUE  = 4'd6,
    ST_DBG_WAIT   = 4'd7,
    ST_ERROR      = 4'd8
  } state_t;

endpackage

// File: rtl/adv7513_cfg_rom.sv
// rtl/adv7513_cfg_rom.sv - combinational {reg_addr, data} init table for the ADV7513
module adv7513_cfg_rom
  import adv7513_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [15:0]      entry
);

  logic [7:0] w_idx8;

  assign w_idx8 = 8'(idx);

  // Table lookup; entries past the populated range read as zero
  always_comb begin
    entry = 16'h0000;
    if (int'(w_idx8) < INIT_LEN) begin
      case (w_idx8)
        8'd0:    entry = 16'h41_10;  // power up the transmitter
        8'd1:    entry = 16'h98_03;  // fixed register
        8'd2:    entry = 16'h9A_E0;  // fixed register
        8'd3:    entry = 16'h9C_30;  // fixed register
        8'd4:    entry = 16'h9D_61;  // fixed register
        8'd5:    entry = 16'hA2_A4;  // fixed register
        8'd6:    entry = 16'hA3_A4;  // fixed register
        8'd7:    entry = 16'hE0_D0;  // fixed register
        8'd8:    entry = 16'hF9_00;  // fixed register
        8'd9:    entry = 16'h15_00;  // input ID: 24-bit RGB 4:4:4
        8'd10:   entry = 16'h16_30;  // output 4:4:4, 8 bit per channel
        8'd11:   entry = 16'h17_02;  // 16:9 aspect ratio
        8'd12:   entry = 16'h18_46;  // colour space converter off
        8'd13:   entry = 16'hAF_06;  // HDMI mode
        8'd14:   entry = 16'h40_80;  // general control packet enable
        8'd15:   entry = 16'hD6_C0;  // HPD forced high
        default: entry = 16'h0000;
      endcase
    end
  end

endmodule

// File: rtl/adv7513_cfg_seq.sv
// rtl/adv7513_cfg_seq.sv - ADV7513 init table writer with hot-plug polling and debug reads
module adv7513_cfg_seq
  import adv7513_pkg::*;
#(
  parameter logic [6:0] CHIP_ADDR   = DEF_CHIP_ADDR,
  parameter int         NUM_REGS    = 16,
  parameter int         MAX_RETRY   = 3,
  parameter int         POLL_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       init_done,
  output logic       error,
  output logic       hpd,
  input  logic       dbg_req,
  input  logic [7:0] dbg_addr,
  output logic       dbg_ack,
  output logic [7:0] dbg_data,
  output logic [6:0] i2c_chip_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_data_in,
  output logic       i2c_write_en,
  output logic       i2c_read_en,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic [2:0] i2c_status,
  input  logic [7:0] i2c_data_out
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REGS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [23:0]   POLL_TERM = 24'(POLL_CYCLES - 1);

  state_t      r_state,    w_state_nxt;
  logic        r_start_q;
  logic [IW-1:0] r_idx,    w_idx_nxt;
  logic [RW-1:0] r_retry,  w_retry_nxt;
  logic [23:0] r_cnt,      w_cnt_nxt;
  logic        r_first,    w_first_nxt;
  logic        r_hpd,      w_hpd_nxt;
  logic [7:0]  r_dbg_data, w_dbg_data_nxt;
  logic        r_dbg_ack,  w_dbg_ack_nxt;
  logic [7:0]  r_dbg_addr, w_dbg_addr_nxt;
  logic        r_dbg_err,  w_dbg_err_nxt;
  logic        w_start_rise;
  logic        w_cmp;
  logic        w_fail;
  logic        w_retry_ok;
  logic [15:0] w_rom_entry;

  adv7513_cfg_rom #(.IDX_W(IW)) u_rom (
    .idx   (r_idx),
    .entry (w_rom_entry)
  );

  assign w_start_rise = start & ~r_start_q;
  // The first WAIT cycle is skipped: the master has not yet raised busy
  assign w_cmp        = ~r_first & i2c_done & ~i2c_busy;
  assign w_fail       = (i2c_status != 3'd0);
  assign w_retry_ok   = (r_retry < RETRY_MAX);

  assign i2c_chip_addr = CHIP_ADDR;
  assign init_done     = (r_state == ST_READY);
  assign error         = (r_state == ST_ERROR);
  assign hpd           = r_hpd;
  assign dbg_ack       = r_dbg_ack;
  assign dbg_data      = r_dbg_data;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_start_q  <= 1'b0;
      r_idx      <= '0;
      r_retry    <= '0;
      r_cnt      <= 24'd0;
      r_first    <= 1'b0;
      r_hpd      <= 1'b0;
      r_dbg_data <= 8'h00;
      r_dbg_ack  <= 1'b0;
      r_dbg_addr <= 8'h00;
      r_dbg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_start_q  <= start;
      r_idx      <= w_idx_nxt;
      r_retry    <= w_retry_nxt;
      r_cnt      <= w_cnt_nxt;
      r_first    <= w_first_nxt;
      r_hpd      <= w_hpd_nxt;
      r_dbg_data <= w_dbg_data_nxt;
      r_dbg_ack  <= w_dbg_ack_nxt;
      r_dbg_addr <= w_dbg_addr_nxt;
      r_dbg_err  <= w_dbg_err_nxt;
    end
  end

  // Next-state, datapath updates and i2c command generation
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_retry_nxt    = r_retry;
    w_cnt_nxt      = r_cnt;
    w_first_nxt    = 1'b0;
    w_hpd_nxt      = r_hpd;
    w_dbg_data_nxt = r_dbg_data;
    w_dbg_ack_nxt  = 1'b0;
    w_dbg_addr_nxt = r_dbg_addr;
    w_dbg_err_nxt  = r_dbg_err;
    i2c_reg_addr   = 8'h00;
    i2c_data_in    = 8'h00;
    i2c_write_en   = 1'b0;
    i2c_read_en    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state_nxt = ST_WR_ISSUE;
          w_idx_nxt   = '0;
          w_retry_nxt = '0;
          w_cnt_nxt   = 24'd0;
        end
      end

      ST_WR_ISSUE, ST_WR_WAIT: begin
        i2c_reg_addr = w_rom_entry[15:8];
        i2c_data_in  = w_rom_entry[7:0];
        if (r_state == ST_WR_ISSUE) begin
          // Hold off the pulse while the master still reports busy
          if (!i2c_busy) begin
            i2c_write_en = 1'b1;
            w_first_nxt  = 1'b1;
            w_state_nxt  = ST_WR_WAIT;
          end
        end else if (w_cmp) begin
          if (!w_fail) begin
            w_retry_nxt = '0;
            if (r_idx == IDX_LAST) begin
              w_state_nxt = ST_READY;
            end else begin
              w_idx_nxt   = r_idx + IW'(1);
              w_state_nxt = ST_WR_ISSUE;
            end
          end else if (w_retry_ok) begin
            w_retry_nxt = r_retry + RW'(1);
            w_state_nxt = ST_WR_ISSUE;
          end else begin
            w_state_nxt = ST_ERROR;
          end
        end
      end

      ST_READY: begin
        // A debug request pre-empts a due poll; the counter stays put so the poll follows
        if (dbg_req) begin
          w_state_nxt    = ST_DBG_ISSUE;
          w_dbg_addr_nxt = dbg_addr;
          w_dbg_err_nxt  = 1'b0;
        end else if (r_cnt == POLL_TERM) begin
          w_state_nxt = ST_POLL_ISSUE;
          w_cnt_nxt   = 24'd0;
          w_retry_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 24'd1;
        end
      end

      ST_POLL_ISSUE, ST_POLL_WAIT: begin
        i2c_reg_addr = REG_HPD;
        if (r_state == ST_POLL_ISSUE) begin
          if (!i2c_busy) begin
            i2c_read_en = 1'b1;
            w_first_nxt = 1'b1;
            w_state_nxt = ST_POLL_WAIT;
          end
        end else if (w_cmp) begin
          if (!w_fail) begin
            w_hpd_nxt   = i2c_data_out[HPD_BIT];
            w_retry_nxt = '0;
            // Freshly plugged sink: reprogram from the top of the table
            if (!r_hpd && i2c_data_out[HPD_BIT]) begin
              w_state_nxt = ST_WR_ISSUE;
              w_idx_nxt   = '0;
            end else begin
              w_state_nxt = ST_READY;
            end
          end else if (w_retry_ok) begin
            w_retry_nxt = r_retry + RW'(1);
            w_state_nxt = ST_POLL_ISSUE;
          end else begin
            w_state_nxt = ST_ERROR;
          end
        end
      end

      ST_DBG_ISSUE, ST_DBG_WAIT: begin
        i2c_reg_addr = r_dbg_addr;
        if (r_state == ST_DBG_ISSUE) begin
          if (!i2c_busy) begin
            i2c_read_en = 1'b1;
            w_first_nxt = 1'b1;
            w_state_nxt = ST_DBG_WAIT;
          end
        end else if (w_cmp) begin
          w_dbg_data_nxt = w_fail ? 8'h00 : i2c_data_out;
          w_dbg_ack_nxt  = 1'b1;
          w_state_nxt    = r_dbg_err ? ST_ERROR : ST_READY;
        end
      end

      ST_ERROR: begin
        if (w_start_rise) begin
          w_state_nxt = ST_WR_ISSUE;
          w_idx_nxt   = '0;
          w_retry_nxt = '0;
          w_cnt_nxt   = 24'd0;
        end else if (dbg_req) begin
          w_state_nxt    = ST_DBG_ISSUE;
          w_dbg_addr_nxt = dbg_addr;
          w_dbg_err_nxt  = 1'b1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adv7513_cfg_seq.sv
// tb/tb_adv7513_cfg_seq.sv - self-checking bench for adv7513_cfg_seq
module tb_adv7513_cfg_seq;

  localparam int MAX_RETRY = 3;

  logic       clk;
  logic       reset;
  logic       start;
  logic       init_done;
  logic       error;
  logic       hpd;
  logic       dbg_req;
  logic [7:0] dbg_addr;
  logic       dbg_ack;
  logic [7:0] dbg_data;
  logic [6:0] i2c_chip_addr;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_data_in;
  logic       i2c_write_en;
  logic       i2c_read_en;
  logic       i2c_busy;
  logic       i2c_done;
  logic [2:0] i2c_status;
  logic [7:0] i2c_data_out;

  int          n_checks;
  int          n_errors;
  int          plan[16];
  int          nack_left[16];
  logic [15:0] wlog[$];
  logic [7:0]  rlog[$];
  logic [7:0]  poll_q[$];
  logic [7:0]  poll_last;
  logic [7:0]  dbg_resp;
  bit          dbg_nack;

  adv7513_cfg_seq #(.POLL_CYCLES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .init_done     (init_done),
    .error         (error),
    .hpd           (hpd),
    .dbg_req       (dbg_req),
    .dbg_addr      (dbg_addr),
    .dbg_ack       (dbg_ack),
    .dbg_data      (dbg_data),
    .i2c_chip_addr (i2c_chip_addr),
    .i2c_reg_addr  (i2c_reg_addr),
    .i2c_data_in   (i2c_data_in),
    .i2c_write_en  (i2c_write_en),
    .i2c_read_en   (i2c_read_en),
    .i2c_busy      (i2c_busy),
    .i2c_done      (i2c_done),
    .i2c_status    (i2c_status),
    .i2c_data_out  (i2c_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [15:0] rom_val(input int i);
    case (i)
      0: return 16'h4110;   1: return 16'h9803;   2: return 16'h9AE0;   3: return 16'h9C30;
      4: return 16'h9D61;   5: return 16'hA2A4;   6: return 16'hA3A4;   7: return 16'hE0D0;
      8: return 16'hF900;   9: return 16'h1500;  10: return 16'h1630;  11: return 16'h1702;
     12: return 16'h1846;  13: return 16'hAF06;  14: return 16'h4080;  15: return 16'hD6C0;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // i2c master stand-in: one cycle latency to busy, random busy length, then a done pulse
  initial begin
    int          lat;
    bit          act;
    bit          pend;
    logic [2:0]  st;
    logic [7:0]  dat;
    logic        we, re, bz;
    logic [7:0]  ra, di;
    logic [15:0] rv;
    lat = 0; act = 0; pend = 0; st = 3'd0; dat = 8'h00;
    i2c_busy = 1'b0; i2c_done = 1'b0; i2c_status = 3'd0; i2c_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        i2c_busy = 1'b0; i2c_done = 1'b0; i2c_status = 3'd0;
        act = 0; pend = 0;
        continue;
      end
      we = i2c_write_en; re = i2c_read_en; bz = i2c_busy;
      ra = i2c_reg_addr; di = i2c_data_in;
      i2c_done = 1'b0;
      if (act) begin
        if (lat > 0) lat--;
        else begin
          i2c_busy = 1'b0; i2c_done = 1'b1; i2c_status = st; i2c_data_out = dat; act = 0;
        end
      end else if (pend) begin
        i2c_busy = 1'b1; lat = $urandom_range(0, 2); act = 1; pend = 0;
      end
      if (we || re) begin
        check("en_exclusive", {31'd0, we & re}, 32'd0);
        check("en_while_busy", {31'd0, bz}, 32'd0);
        pend = 1; st = 3'd0; dat = 8'h00;
        if (we) begin
          wlog.push_back({ra, di});
          for (int j = 0; j < 16; j++) begin
            rv = rom_val(j);
            if (rv[15:8] == ra && nack_left[j] > 0) begin
              st = 3'd1;
              nack_left[j]--;
            end
          end
        end else begin
          rlog.push_back(ra);
          if (ra == 8'h42) begin
            if (poll_q.size() > 0) poll_last = poll_q.pop_front();
            dat = poll_last;
          end else begin
            dat = dbg_resp;
            if (dbg_nack) st = 3'd1;
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b0; start = 1'b0; dbg_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (init_done || error) break;
    end
    check({tag, "_finished"}, {31'd0, init_done | error}, 32'd1);
  endtask

  // Expected writes follow from the NACK plan: each entry is tried plan+1 times,
  // capped at MAX_RETRY+1 attempts, after which the sequence stops in error
  task automatic run_table(input string tag, input bit poke);
    logic [15:0] exp_q[$];
    bit          exp_err;
    int          n;
    exp_err = 0;
    for (int i = 0; i < 16 && !exp_err; i++) begin
      n = (plan[i] > MAX_RETRY) ? MAX_RETRY + 1 : plan[i] + 1;
      repeat (n) exp_q.push_back(rom_val(i));
      if (plan[i] > MAX_RETRY) exp_err = 1;
    end
    for (int i = 0; i < 16; i++) nack_left[i] = plan[i];
    wlog.delete();
    pulse_start();
    if (poke) begin
      for (int k = 0; k < 300 && wlog.size() < 3; k++) @(negedge clk);
      pulse_start();
    end
    wait_end(tag, 3000);
    check({tag, "_count"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      check({tag, "_wr"}, {16'd0, wlog[i]}, {16'd0, exp_q[i]});
    check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    check({tag, "_done"}, {31'd0, init_done}, {31'd0, !exp_err});
  endtask

  task automatic do_dbg(input string tag, input logic [7:0] addr, input logic [7:0] exp_data,
                        input int exp_reads);
    dbg_addr = addr;
    dbg_req  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dbg_ack) break;
    end
    check({tag, "_ack"}, {31'd0, dbg_ack}, 32'd1);
    check({tag, "_data"}, {24'd0, dbg_data}, {24'd0, exp_data});
    check({tag, "_reads"}, rlog.size(), exp_reads);
    dbg_req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_pulse"}, {31'd0, dbg_ack}, 32'd0);
  endtask

  initial begin
    int n;
    n_checks = 0; n_errors = 0;
    reset = 1'b0; start = 1'b0; dbg_req = 1'b0; dbg_addr = 8'h00;
    poll_last = 8'h00; dbg_resp = 8'h00; dbg_nack = 0;
    for (int i = 0; i < 16; i++) begin plan[i] = 0; nack_left[i] = 0; end

    repeat (3) @(negedge clk);
    check("rst_write_en", {31'd0, i2c_write_en}, 32'd0);
    check("rst_read_en",  {31'd0, i2c_read_en},  32'd0);
    check("rst_init_done",{31'd0, init_done},    32'd0);
    check("rst_error",    {31'd0, error},        32'd0);
    check("rst_hpd",      {31'd0, hpd},          32'd0);
    check("rst_dbg_ack",  {31'd0, dbg_ack},      32'd0);
    check("rst_dbg_data", {24'd0, dbg_data},     32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("chip_addr", {25'd0, i2c_chip_addr}, 32'h39);

    // Clean init with a start edge mid-run that must be ignored
    run_table("init_all", 1);

    // Entry 3 NACKed twice then accepted
    apply_reset();
    plan[3] = 2;
    run_table("nack2", 0);

    // Entry 3 NACKed past the retry limit
    apply_reset();
    plan[3] = 4;
    run_table("nack4", 0);

    // Debug read from ERROR that fails: data reads zero, no retry, stays in ERROR
    rlog.delete();
    dbg_nack = 1; dbg_resp = 8'h5A;
    do_dbg("dbg_err", 8'h00, 8'h00, 1);
    repeat (4) @(negedge clk);
    check("dbg_err_stay", {31'd0, error}, 32'd1);
    check("dbg_err_noretry", rlog.size(), 1);
    dbg_nack = 0;

    // Start edge leaves ERROR and reruns the table
    plan[3] = 0;
    run_table("rerun_err", 0);

    // Hot-plug: first poll sees 0, second sees bit 6 set -> table rerun
    apply_reset();
    poll_q.delete(); poll_q.push_back(8'h00); poll_q.push_back(8'h40);
    poll_last = 8'h00;
    rlog.delete();
    run_table("poll_init", 0);
    wlog.delete();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (hpd) break;
    end
    check("hpd_rise", {31'd0, hpd}, 32'd1);
    check("hpd_rerun_busy", {31'd0, init_done}, 32'd0);
    check("poll_reads", rlog.size(), 2);
    for (int i = 0; i < rlog.size() && i < 2; i++)
      check("poll_addr", {24'd0, rlog[i]}, 32'h42);
    wait_end("hpd_rerun", 3000);
    check("hpd_rerun_count", wlog.size(), 16);
    for (int i = 0; i < wlog.size() && i < 16; i++)
      check("hpd_rerun_wr", {16'd0, wlog[i]}, {16'd0, rom_val(i)});
    check("hpd_hold", {31'd0, hpd}, 32'd1);

    // Debug request arriving in the cycle the poll falls due wins; poll follows
    repeat (15) @(negedge clk);
    rlog.delete();
    dbg_resp = 8'h13;
    do_dbg("dbg_ready", 8'h00, 8'h13, 1);
    if (rlog.size() > 0) check("dbg_ready_addr", {24'd0, rlog[0]}, 32'h00);
    repeat (6) @(negedge clk);
    check("deferred_poll_count", rlog.size(), 2);
    if (rlog.size() > 1) check("deferred_poll_addr", {24'd0, rlog[1]}, 32'h42);

    // Reset during WR_WAIT of entry 5 of a hot-plug rerun
    wlog.delete();
    poll_q.push_back(8'h00); poll_q.push_back(8'h40);
    for (int k = 0; k < 1000 && wlog.size() < 6; k++) @(negedge clk);
    check("mid_reach5", wlog.size(), 6);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_write_en", {31'd0, i2c_write_en}, 32'd0);
    check("mid_read_en",  {31'd0, i2c_read_en},  32'd0);
    check("mid_init_done",{31'd0, init_done},    32'd0);
    check("mid_error",    {31'd0, error},        32'd0);
    check("mid_hpd",      {31'd0, hpd},          32'd0);
    check("mid_dbg_ack",  {31'd0, dbg_ack},      32'd0);
    check("mid_dbg_data", {24'd0, dbg_data},     32'd0);
    n = wlog.size();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    poll_last = 8'h00;
    repeat (4) @(negedge clk);
    check("mid_no_pulses", wlog.size(), n);
    check("mid_idle", {31'd0, init_done}, 32'd0);
    run_table("after_reset", 0);

    // Randomized NACK plans
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      poll_q.delete();
      poll_last = 8'h00;
      for (int i = 0; i < 16; i++)
        plan[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_table("rand", 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
